alu_operand_stage: RTL and testbench

Decode/operand-select pipeline stage directly upstream of the execute ALU. Accepts one RV32I instruction's decoded fields plus register-file read data, PC and immediate. Produces registered `op1`, `op2` and the 4-bit `aluSel` code the ALU consumes. Sits behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput and a registered `in_ready`.

---
 rtl/alu_operand_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Decode/operand-select stage feeding the execute ALU. Decodes one RV32I
// instruction per accepted transfer into {op1, op2, aluSel, illegal} and
// holds it in a two-entry skid buffer (main + skid) so that in_ready can
// be a flop with no combinational path from out_ready.

module alu_operand_stage (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  aluSel,
    output logic        illegal
);

    // ALU operation codes consumed downstream
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_COPY1 = 4'd10;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  sel;
        logic        ill;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Register-register / register-immediate arithmetic map; b5 picks the
    // SUB and SRA variants (callers force b5 low where it must not apply).
    function automatic logic [3:0] arith_sel(input logic [2:0] f3, input logic b5);
        logic [3:0] s;
        case (f3)
            3'b000:  s = b5 ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

    entry_t dec;
    logic   dec_bad;
    logic   f3_has_b5;

    // bit 30 is only meaningful for funct3 000 and 101
    assign f3_has_b5 = (funct3 == 3'b000) || (funct3 == 3'b101);

    // Combinational decode of the offered instruction; an illegal encoding
    // collapses to zero operands with ADD so the ALU sees a benign op.
    always_comb begin
        dec     = '0;
        dec_bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.op1 = rs1Data;
                dec.op2 = rs2Data;
                dec.sel = arith_sel(funct3, funct7b5);
                dec_bad = funct7b5 && !f3_has_b5;
            end
            OPC_OPIMM: begin
                dec.op1 = rs1Data;
                dec.op2 = imm;
                dec.sel = arith_sel(funct3, funct7b5 && (funct3 == 3'b101));
                dec_bad = funct7b5 && !f3_has_b5;
            end
            OPC_LUI: begin
                dec.op1 = imm;
                dec.op2 = '0;
                dec.sel = ALU_COPY1;
            end
            OPC_AUIPC: begin
                dec.op1 = pc;
                dec.op2 = imm;
                dec.sel = ALU_ADD;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.op1 = rs1Data;
                dec.op2 = imm;
                dec.sel = ALU_ADD;
            end
            OPC_JAL, OPC_JALR: begin
                dec.op1 = pc;
                dec.op2 = 32'd4;
                dec.sel = ALU_ADD;
            end
            OPC_BRANCH: begin
                dec.op1 = rs1Data;
                dec.op2 = rs2Data;
                case (funct3)
                    3'b000, 3'b001: dec.sel = ALU_SUB;
                    3'b100, 3'b101: dec.sel = ALU_SLT;
                    3'b110, 3'b111: dec.sel = ALU_SLTU;
                    default:        dec_bad = 1'b1;
                endcase
            end
            default: dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
            dec     = '0;
            dec.ill = 1'b1;
        end
    end

    state_t state_q, state_d;
    entry_t main_q, skid_q;
    logic   in_ready_q;
    logic   accept, drain;
    logic   ld_main_dec, ld_main_skid, ld_skid;

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != S_EMPTY) && out_ready;

    // Next-state and load-enable decode for the two-entry buffer
    always_comb begin
        state_d      = state_q;
        ld_main_dec  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d     = S_ONE;
                    ld_main_dec = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && !drain) begin
                    state_d = S_TWO;
                    ld_skid = 1'b1;
                end else if (drain && !accept) begin
                    state_d = S_EMPTY;
                end else if (accept && drain) begin
                    ld_main_dec = 1'b1;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    state_d      = S_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d      = S_EMPTY;
            ld_main_dec  = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // State, storage and the registered in_ready (low exactly while in TWO)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
            if (ld_main_dec)
                main_q <= dec;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= dec;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign op1       = main_q.op1;
    assign op2       = main_q.op2;
    assign aluSel    = main_q.sel;
    assign illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a table of decode vectors with hand-computed
// expected entries, a scoreboard queue filled on accept and drained on
// output transfer, plus directed backpressure / flush / reset sequences.

module tb_alu_operand_stage;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0001111;
    localparam int NV = 24;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b5;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [68:0] exp;   // {op1, op2, aluSel, illegal}
    } vec_t;

    logic        clk, rst, flush, in_valid, in_ready, funct7b5;
    logic        out_valid, out_ready, illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1Data, rs2Data, imm, pc, op1, op2;
    logic [3:0]  aluSel;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .aluSel(aluSel), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [68:0] sb[$];
    logic [68:0] cur_exp;
    vec_t        tbl[NV];
    wire  [68:0] dut_ent = {op1, op2, aluSel, illegal};

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic b,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [31:0] p,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [3:0] es, input logic ei);
        vec_t v;
        v.opc = o; v.f3 = f; v.b5 = b; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.pc = p;
        v.exp = {e1, e2, es, ei};
        return v;
    endfunction

    // Scoreboard: compare on output transfer, record on accept. Flush and
    // reset empty the buffer, so they empty the queue as well.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %0h expected no output", dut_ent);
                end else begin
                    chk("scoreboard", {3'b0, dut_ent}, {3'b0, sb.pop_front()});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        opcode = v.opc; funct3 = v.f3; funct7b5 = v.b5;
        rs1Data = v.rs1; rs2Data = v.rs2; imm = v.imm; pc = v.pc;
        cur_exp = v.exp;
        in_valid = 1'b1;
    endtask

    // Offer one entry until accepted; returns the number of stalled cycles.
    task automatic send(input vec_t v, output int waited);
        logic got;
        drive(v);
        waited = 0;
        forever begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
            waited++;
            if (waited > 50) begin
                n_chk++;
                $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 100), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w, stalls;
        tbl[0]  = mk(OP,  3'b000, 1'b0, 32'd5,        32'd7, 32'h0,       32'h0,   32'd5,        32'd7,       4'd0,  1'b0);
        tbl[1]  = mk(OP,  3'b000, 1'b1, 32'd9,        32'd3, 32'h0,       32'h0,   32'd9,        32'd3,       4'd1,  1'b0);
        tbl[2]  = mk(OP,  3'b101, 1'b1, 32'h80000000, 32'd4, 32'h11,      32'h0,   32'h80000000, 32'd4,       4'd9,  1'b0);
        tbl[3]  = mk(OPI, 3'b000, 1'b1, 32'h10,       32'h2, 32'hFFFFFC00,32'h0,   32'h10,       32'hFFFFFC00,4'd0,  1'b0);
        tbl[4]  = mk(LUI, 3'b000, 1'b0, 32'hDEAD,     32'h3, 32'h12345000,32'h4,   32'h12345000, 32'h0,       4'd10, 1'b0);
        tbl[5]  = mk(JAL, 3'b000, 1'b0, 32'h55,       32'h6, 32'h40,      32'h100, 32'h100,      32'd4,       4'd0,  1'b0);
        tbl[6]  = mk(BR,  3'b110, 1'b0, 32'h1,        32'h2, 32'h8,       32'h20,  32'h1,        32'h2,       4'd6,  1'b0);
        tbl[7]  = mk(BR,  3'b010, 1'b0, 32'h1,        32'h2, 32'h8,       32'h20,  32'h0,        32'h0,       4'd0,  1'b1);
        tbl[8]  = mk(AUI, 3'b000, 1'b0, 32'h33,       32'h44,32'h1000,    32'h200, 32'h200,      32'h1000,    4'd0,  1'b0);
        tbl[9]  = mk(LD,  3'b010, 1'b0, 32'h400,      32'h77,32'h8,       32'h24,  32'h400,      32'h8,       4'd0,  1'b0);
        tbl[10] = mk(ST,  3'b010, 1'b1, 32'h500,      32'h78,32'hFFFFFFFC,32'h28,  32'h500,      32'hFFFFFFFC,4'd0,  1'b0);
        tbl[11] = mk(JLR, 3'b000, 1'b0, 32'h9,        32'h79,32'h10,      32'h300, 32'h300,      32'd4,       4'd0,  1'b0);
        tbl[12] = mk(OP,  3'b001, 1'b0, 32'h1,        32'h3, 32'h0,       32'h0,   32'h1,        32'h3,       4'd7,  1'b0);
        tbl[13] = mk(OP,  3'b111, 1'b0, 32'hF0F0,     32'hFF,32'h0,       32'h0,   32'hF0F0,     32'hFF,      4'd2,  1'b0);
        tbl[14] = mk(OP,  3'b100, 1'b1, 32'hAA,       32'hBB,32'h0,       32'h0,   32'h0,        32'h0,       4'd0,  1'b1);
        tbl[15] = mk(OPI, 3'b101, 1'b0, 32'hF0,       32'hCC,32'h4,       32'h0,   32'hF0,       32'h4,       4'd8,  1'b0);
        tbl[16] = mk(BAD, 3'b000, 1'b0, 32'h12,       32'h34,32'h56,      32'h78,  32'h0,        32'h0,       4'd0,  1'b1);
        tbl[17] = mk(BR,  3'b101, 1'b0, 32'h7,        32'h8, 32'h0,       32'h0,   32'h7,        32'h8,       4'd5,  1'b0);
        tbl[18] = mk(OP,  3'b011, 1'b0, 32'h21,       32'h22,32'h0,       32'h0,   32'h21,       32'h22,      4'd6,  1'b0);
        tbl[19] = mk(OP,  3'b110, 1'b0, 32'h31,       32'h32,32'h0,       32'h0,   32'h31,       32'h32,      4'd3,  1'b0);
        tbl[20] = mk(OP,  3'b010, 1'b0, 32'h41,       32'h42,32'h0,       32'h0,   32'h41,       32'h42,      4'd5,  1'b0);
        tbl[21] = mk(OP,  3'b100, 1'b0, 32'h51,       32'h52,32'h0,       32'h0,   32'h51,       32'h52,      4'd4,  1'b0);
        tbl[22] = mk(OPI, 3'b101, 1'b1, 32'h61,       32'h62,32'h403,     32'h0,   32'h61,       32'h403,     4'd9,  1'b0);
        tbl[23] = mk(BR,  3'b000, 1'b0, 32'h71,       32'h72,32'h0,       32'h0,   32'h71,       32'h72,      4'd1,  1'b0);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        rs1Data = '0; rs2Data = '0; imm = '0; pc = '0; cur_exp = '0;

        // reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", {out_valid, in_ready, dut_ent}, {1'b0, 1'b1, 69'h0});
        rst = 1'b1;
        @(posedge clk);
        #1;

        // first-entry latency, then a back-to-back stream of the whole table
        out_ready = 1'b1;
        send(tbl[0], w);
        chk("first_latency", {out_valid, op1, op2, aluSel}, {1'b1, 32'd5, 32'd7, 4'd0});
        stalls = w;
        for (int i = 1; i < NV; i++) begin
            send(tbl[i], w);
            stalls += w;
        end
        chk("full_throughput_stalls", stalls, 0);
        wait_empty();

        // backpressure: two entries fill the buffer, third waits
        out_ready = 1'b0;
        send(tbl[2], w);
        send(tbl[4], w);
        drive(tbl[5]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready_low", in_ready, 0);
            chk("hold_stable", {3'b0, dut_ent}, {3'b0, tbl[2].exp});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(tbl[5], w);
        wait_empty();
        chk("in_ready_restored", in_ready, 1);

        // flush in TWO with an entry offered
        out_ready = 1'b0;
        send(tbl[6], w);
        send(tbl[8], w);
        drive(tbl[9]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_two_state", {out_valid, in_ready}, {1'b0, 1'b1});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // flush in ONE while in_ready is high: offered entry still dropped
        out_ready = 1'b0;
        send(tbl[12], w);
        drive(tbl[13]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_one_state", {out_valid, in_ready}, {1'b0, 1'b1});
        @(posedge clk);
        #1;

        // reset mid-cycle while in TWO
        send(tbl[12], w);
        send(tbl[13], w);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_values", {out_valid, in_ready, dut_ent}, {1'b0, 1'b1, 69'h0});
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(tbl[17], w);
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
